// File: rtl/alu_sequencer_if.sv
// Instruction handshake and datapath control bundle between the sequencer and
// whatever feeds it instructions and consumes its controls.
interface alu_sequencer_if;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [4:0]  flags;
    logic [7:0]  aluOp;
    logic [4:0]  RegEn;
    logic [4:0]  BufEnA;
    logic [4:0]  BufEnB;
    logic [15:0] imm;
    logic        immEn;
    logic        cin;
    logic [4:0]  psr;
    logic        done;
    logic        illegal;

    // Sequencer side
    modport slave (
        input  instr, instr_valid, flags,
        output instr_ready, aluOp, RegEn, BufEnA, BufEnB, imm, immEn, cin, psr, done, illegal
    );

    // Instruction source / datapath side
    modport master (
        output instr, instr_valid, flags,
        input  instr_ready, aluOp, RegEn, BufEnA, BufEnB, imm, immEn, cin, psr, done, illegal
    );
endinterface

// File: rtl/alu_sequencer.sv
// Three-state instruction sequencer: accepts a 16-bit instruction in IDLE, drives
// decoded datapath controls for one EXEC cycle, then pulses done in RETIRE.
module alu_sequencer (
    input logic            clk,
    input logic            reset,
    alu_sequencer_if.slave bus
);

    localparam logic [4:0] NoReg = 5'd16;

    typedef enum logic [1:0] {StIdle, StExec, StRetire} state_e;

    state_e      state_q, state_d;
    logic [7:0]  op_q, op_d;
    logic [4:0]  reg_en_q, reg_en_d;
    logic [4:0]  buf_a_q, buf_a_d;
    logic [4:0]  buf_b_q, buf_b_d;
    logic [15:0] imm_q, imm_d;
    logic        imm_en_q, imm_en_d;
    logic        use_cin_q, use_cin_d;
    logic        upd_psr_q, upd_psr_d;
    logic        illegal_q, illegal_d;
    logic [4:0]  psr_q, psr_d;

    logic        accept;
    logic        is_rr;
    logic [3:0]  code;
    logic [3:0]  rdest;
    logic [3:0]  rsrc;
    logic        legal;
    logic        is_mov;
    logic        is_cmp;
    logic        sext;
    logic [15:0] imm_ext;

    assign accept = (state_q == StIdle) && bus.instr_valid;

    // Next-state sequencing: one cycle per state, IDLE waits for a valid instruction
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (bus.instr_valid) state_d = StExec;
            StExec:   state_d = StRetire;
            StRetire: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Instruction field extraction and legality
    always_comb begin
        is_rr   = (bus.instr[15:12] == 4'h0);
        code    = is_rr ? bus.instr[7:4] : bus.instr[15:12];
        rdest   = bus.instr[11:8];
        rsrc    = bus.instr[3:0];
        legal   = 1'b0;
        case (code)
            4'h1, 4'h2, 4'h3, 4'h5, 4'h7, 4'h9, 4'hA, 4'hB, 4'hD: legal = 1'b1;
            default: legal = 1'b0;
        endcase
        is_mov  = (code == 4'hD);
        is_cmp  = (code == 4'hB);
        // Logical ops zero-extend, arithmetic and MOV sign-extend
        sext    = !((code == 4'h1) || (code == 4'h2) || (code == 4'h3));
        imm_ext = sext ? {{8{bus.instr[7]}}, bus.instr[7:0]} : {8'h00, bus.instr[7:0]};
    end

    // Latch decoded controls on accept; capture flags into psr leaving EXEC
    always_comb begin
        op_d      = op_q;
        reg_en_d  = reg_en_q;
        buf_a_d   = buf_a_q;
        buf_b_d   = buf_b_q;
        imm_d     = imm_q;
        imm_en_d  = imm_en_q;
        use_cin_d = use_cin_q;
        upd_psr_d = upd_psr_q;
        illegal_d = illegal_q;
        psr_d     = psr_q;

        if (accept) begin
            if (!legal) begin
                op_d      = 8'h00;
                reg_en_d  = NoReg;
                buf_a_d   = NoReg;
                buf_b_d   = NoReg;
                imm_d     = 16'h0000;
                imm_en_d  = 1'b0;
                use_cin_d = 1'b0;
                upd_psr_d = 1'b0;
                illegal_d = 1'b1;
            end else begin
                op_d      = is_mov ? 8'h05 : {4'h0, code};
                reg_en_d  = is_cmp ? NoReg : {1'b0, rdest};
                use_cin_d = (code == 4'h7) || (code == 4'hA);
                upd_psr_d = !is_mov;
                illegal_d = 1'b0;
                if (is_rr) begin
                    // RR MOV routes Rsrc through bus A and adds a zero immediate
                    buf_a_d  = is_mov ? {1'b0, rsrc} : {1'b0, rdest};
                    buf_b_d  = {1'b0, rsrc};
                    imm_en_d = is_mov;
                    imm_d    = 16'h0000;
                end else begin
                    // Immediate MOV disables bus A so the result is the immediate itself
                    buf_a_d  = is_mov ? NoReg : {1'b0, rdest};
                    buf_b_d  = NoReg;
                    imm_en_d = 1'b1;
                    imm_d    = imm_ext;
                end
            end
        end

        if ((state_q == StExec) && upd_psr_q) begin
            psr_d = bus.flags;
        end
    end

    // State and control registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            op_q      <= 8'h00;
            reg_en_q  <= NoReg;
            buf_a_q   <= NoReg;
            buf_b_q   <= NoReg;
            imm_q     <= 16'h0000;
            imm_en_q  <= 1'b0;
            use_cin_q <= 1'b0;
            upd_psr_q <= 1'b0;
            illegal_q <= 1'b0;
            psr_q     <= 5'd0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            reg_en_q  <= reg_en_d;
            buf_a_q   <= buf_a_d;
            buf_b_q   <= buf_b_d;
            imm_q     <= imm_d;
            imm_en_q  <= imm_en_d;
            use_cin_q <= use_cin_d;
            upd_psr_q <= upd_psr_d;
            illegal_q <= illegal_d;
            psr_q     <= psr_d;
        end
    end

    // Output drive: controls only during EXEC, idle everywhere else
    always_comb begin
        // Gate with reset so ready drops the instant reset asserts
        bus.instr_ready = reset && (state_q == StIdle);
        bus.done        = (state_q == StRetire);
        bus.illegal     = (state_q == StRetire) && illegal_q;
        bus.psr         = psr_q;
        bus.aluOp       = 8'h00;
        bus.RegEn       = NoReg;
        bus.BufEnA      = NoReg;
        bus.BufEnB      = NoReg;
        bus.imm         = 16'h0000;
        bus.immEn       = 1'b0;
        bus.cin         = 1'b0;
        if (state_q == StExec) begin
            bus.aluOp  = op_q;
            bus.RegEn  = reg_en_q;
            bus.BufEnA = buf_a_q;
            bus.BufEnB = buf_b_q;
            bus.imm    = imm_q;
            bus.immEn  = imm_en_q;
            bus.cin    = use_cin_q & psr_q[0];
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: directed instructions push hand-computed
// expectations; a negedge monitor pops them on accept and checks EXEC and RETIRE.
module tb_alu_sequencer;

    logic clk;
    logic reset;
    alu_sequencer_if bus_if ();

    alu_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] instr;
        logic [7:0]  op;
        logic [4:0]  reg_en;
        logic [4:0]  buf_a;
        logic [4:0]  buf_b;
        logic [15:0] imm;
        logic        imm_en;
        logic        cin;
        logic [4:0]  psr;
        logic        ill;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   acc_cyc[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    int   phase    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Monitor: detect accept at negedge, check EXEC one cycle later, RETIRE after that
    always @(negedge clk) begin
        if (!reset) begin
            phase = 0;
        end else begin
            if (phase == 1) begin
                chk("exec aluOp",  {24'h0, bus_if.aluOp},  {24'h0, cur.op});
                chk("exec RegEn",  {27'h0, bus_if.RegEn},  {27'h0, cur.reg_en});
                chk("exec BufEnA", {27'h0, bus_if.BufEnA}, {27'h0, cur.buf_a});
                chk("exec BufEnB", {27'h0, bus_if.BufEnB}, {27'h0, cur.buf_b});
                chk("exec imm",    {16'h0, bus_if.imm},    {16'h0, cur.imm});
                chk("exec immEn",  {31'h0, bus_if.immEn},  {31'h0, cur.imm_en});
                chk("exec cin",    {31'h0, bus_if.cin},    {31'h0, cur.cin});
                chk("exec ready",  {31'h0, bus_if.instr_ready}, 32'h0);
                chk("exec done",   {31'h0, bus_if.done},   32'h0);
                phase = 2;
            end else if (phase == 2) begin
                chk("retire done",    {31'h0, bus_if.done},    32'h1);
                chk("retire illegal", {31'h0, bus_if.illegal}, {31'h0, cur.ill});
                chk("retire psr",     {27'h0, bus_if.psr},     {27'h0, cur.psr});
                chk("retire RegEn",   {27'h0, bus_if.RegEn},   32'd16);
                phase = 0;
            end
            if (phase == 0 && bus_if.instr_ready && bus_if.instr_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected accept", 32'h1, 32'h0);
                end else begin
                    cur = exp_q.pop_front();
                    acc_cyc.push_back(cyc);
                    phase = 1;
                end
            end
        end
    end

    // Called just after a posedge; returns at the accept posedge
    task automatic issue(input logic [15:0] ins, input logic [4:0] fl, input logic [7:0] op,
                         input logic [4:0] re, input logic [4:0] a, input logic [4:0] b,
                         input logic [15:0] im, input logic ie, input logic ci,
                         input logic [4:0] ps, input logic il);
        exp_t e;
        int   n;
        #1;
        bus_if.instr       = ins;
        bus_if.instr_valid = 1'b1;
        e = '{instr: ins, op: op, reg_en: re, buf_a: a, buf_b: b, imm: im, imm_en: ie,
              cin: ci, psr: ps, ill: il};
        exp_q.push_back(e);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus_if.instr_ready && n < 20);
        if (!bus_if.instr_ready) chk("accept timeout", 32'h0, 32'h1);
        // Flags for this instruction only once the previous one has captured its own
        bus_if.flags = fl;
        @(posedge clk);
    endtask

    task automatic gap(input int n);
        #1;
        bus_if.instr_valid = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    initial begin
        int k0;
        int w;
        reset              = 1'b0;
        bus_if.instr       = 16'h0;
        bus_if.instr_valid = 1'b0;
        bus_if.flags       = 5'd0;

        repeat (5) @(negedge clk);
        chk("rst RegEn",  {27'h0, bus_if.RegEn},  32'd16);
        chk("rst BufEnA", {27'h0, bus_if.BufEnA}, 32'd16);
        chk("rst BufEnB", {27'h0, bus_if.BufEnB}, 32'd16);
        chk("rst immEn",  {31'h0, bus_if.immEn},  32'h0);
        chk("rst psr",    {27'h0, bus_if.psr},    32'h0);
        chk("rst ready",  {31'h0, bus_if.instr_ready}, 32'h0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 chk("release ready", {31'h0, bus_if.instr_ready}, 32'h1);
        @(posedge clk);

        //     instr     flags     op     RegEn  A      B      imm        iE  cin psr     ill
        issue(16'h5012, 5'b00000, 8'h05, 5'd0,  5'd0,  5'd16, 16'h0012, 1, 0, 5'b00000, 0);
        gap(3);
        issue(16'h53F0, 5'b00011, 8'h05, 5'd3,  5'd3,  5'd16, 16'hFFF0, 1, 0, 5'b00011, 0);
        gap(3);
        issue(16'h13F0, 5'b00100, 8'h01, 5'd3,  5'd3,  5'd16, 16'h00F0, 1, 0, 5'b00100, 0);
        gap(3);
        issue(16'h0291, 5'b01000, 8'h09, 5'd2,  5'd2,  5'd1,  16'h0000, 0, 0, 5'b01000, 0);
        gap(2);
        issue(16'h02B1, 5'b10001, 8'h0B, 5'd16, 5'd2,  5'd1,  16'h0000, 0, 0, 5'b10001, 0);
        gap(4);
        issue(16'h0173, 5'b00000, 8'h07, 5'd1,  5'd1,  5'd3,  16'h0000, 0, 1, 5'b00000, 0);
        gap(3);
        issue(16'h0041, 5'b11111, 8'h00, 5'd16, 5'd16, 5'd16, 16'h0000, 0, 0, 5'b00000, 1);
        gap(3);
        issue(16'hD4FE, 5'b10101, 8'h05, 5'd4,  5'd16, 5'd16, 16'hFFFE, 1, 0, 5'b00000, 0);
        gap(3);

        // Back-to-back with instr_valid held high
        k0 = acc_cyc.size();
        issue(16'h05D7, 5'b11111, 8'h05, 5'd5,  5'd7,  5'd7,  16'h0000, 1, 0, 5'b00000, 0);
        issue(16'hA680, 5'b00001, 8'h0A, 5'd6,  5'd6,  5'd16, 16'hFF80, 1, 0, 5'b00001, 0);
        issue(16'h7701, 5'b00000, 8'h07, 5'd7,  5'd7,  5'd16, 16'h0001, 1, 1, 5'b00000, 0);
        issue(16'h3805, 5'b00010, 8'h03, 5'd8,  5'd8,  5'd16, 16'h0005, 1, 0, 5'b00010, 0);
        gap(4);
        for (int i = 1; i < 4; i++) begin
            if (acc_cyc.size() > k0 + i)
                chk("b2b spacing", acc_cyc[k0 + i] - acc_cyc[k0 + i - 1], 32'd3);
            else
                chk("b2b accept missing", 32'h0, 32'h1);
        end

        // Reset pulsed during EXEC
        issue(16'h5012, 5'b11111, 8'h05, 5'd0,  5'd0,  5'd16, 16'h0012, 1, 0, 5'b11111, 0);
        #2;
        reset              = 1'b0;
        bus_if.instr_valid = 1'b0;
        #1;
        chk("midrst aluOp",  {24'h0, bus_if.aluOp},  32'h0);
        chk("midrst RegEn",  {27'h0, bus_if.RegEn},  32'd16);
        chk("midrst BufEnA", {27'h0, bus_if.BufEnA}, 32'd16);
        chk("midrst immEn",  {31'h0, bus_if.immEn},  32'h0);
        chk("midrst ready",  {31'h0, bus_if.instr_ready}, 32'h0);
        chk("midrst psr",    {27'h0, bus_if.psr},    32'h0);
        chk("midrst done",   {31'h0, bus_if.done},   32'h0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 chk("post-rst ready", {31'h0, bus_if.instr_ready}, 32'h1);

        // psr was cleared, so ADDC carries in 0; illegal opcode leaves psr alone
        issue(16'h0173, 5'b00000, 8'h07, 5'd1,  5'd1,  5'd3,  16'h0000, 0, 0, 5'b00000, 0);
        gap(3);
        issue(16'hF123, 5'b11111, 8'h00, 5'd16, 5'd16, 5'd16, 16'h0000, 0, 0, 5'b00000, 1);
        gap(4);

        w = 0;
        while ((exp_q.size() != 0 || phase != 0) && w < 20) begin
            @(posedge clk);
            w++;
        end
        if (exp_q.size() != 0 || phase != 0) chk("drain timeout", 32'h0, 32'h1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
